// File: rtl/rfg_protocol_pkg.sv
// Register-protocol framing definitions shared by the stream arbiter,
// the protocol engine and the readback routing logic.
package rfg_protocol_pkg;

    localparam int HDR_WRITE_BIT          = 0;
    localparam int HDR_READ_BIT           = 1;
    localparam int RFG_FRAME_HEADER_BYTES = 4;

    // Header byte layout, MSB first
    typedef struct packed {
        logic [3:0] vchannel;
        logic       rsvd;
        logic       address_increment;
        logic       read;
        logic       write;
    } header_t;

    // Arbiter position within the frame currently being forwarded
    typedef enum logic [2:0] {
        ARB     = 3'd0,
        HDR     = 3'd1,
        ADDR    = 3'd2,
        LENA    = 3'd3,
        LENB    = 3'd4,
        PAYLOAD = 3'd5
    } arb_state_t;

endpackage

// File: rtl/rfg_rr_grant.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// scanning circularly over NUM_PORTS requesters.
module rfg_rr_grant #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [2:0]           rr_ptr,
    output logic [2:0]           grant,
    output logic                 grant_valid
);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [2*NUM_PORTS-1:0] req_rot;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl >> rr_ptr;

    // Lowest set bit of the rotated vector, mapped back to a port index
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_valid && req_rot[i]) begin
                grant_valid = 1'b1;
                if (int'(rr_ptr) + i >= NUM_PORTS) begin
                    grant = 3'(int'(rr_ptr) + i - NUM_PORTS);
                end else begin
                    grant = 3'(int'(rr_ptr) + i);
                end
            end
        end
    end

endmodule

// File: rtl/rfg_axis_frame_arbiter.sv
// Frame-aware AXI-Stream arbiter: shares the register-protocol engine
// between several byte-stream interfaces, switching only on frame ends
// and tagging every byte with the ID of its source port.
module rfg_axis_frame_arbiter
    import rfg_protocol_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int ID_DEST_WIDTH = 8,
    parameter int ID_BASE       = 0
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [ID_DEST_WIDTH-1:0]        m_axis_tid,
    output logic                            m_axis_tlast,
    output logic [2:0]                      grant_index,
    output logic                            busy,
    output logic [15:0]                     frame_count
);

    arb_state_t            state, state_nxt;
    logic [2:0]            rr_ptr;
    logic [2:0]            rr_grant;
    logic                  rr_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  out_free;
    logic                  accept;
    logic                  byte_last;
    logic                  is_write;
    logic [7:0]            len_lsb;
    logic [16:0]           pay_cnt;

    rfg_rr_grant #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_grant (
        .req         (s_axis_tvalid),
        .rr_ptr      (rr_ptr),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // Route the granted port's byte and valid to the output stage
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_index == 3'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_axis_tvalid[i];
            end
        end
    end

    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign accept   = (state != ARB) && sel_valid && out_free;
    assign busy     = (state != ARB);

    // Only the locked port sees ready, and only when the output register can take a byte
    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if ((state != ARB) && out_free && (grant_index == 3'(i))) begin
                s_axis_tready[i] = 1'b1;
            end
        end
    end

    // Frame parser: next state and end-of-frame marking of the accepted byte
    always_comb begin
        state_nxt = state;
        byte_last = 1'b0;
        case (state)
            ARB: begin
                if (rr_valid) state_nxt = HDR;
            end
            HDR: begin
                if (accept) begin
                    if (sel_data[HDR_WRITE_BIT] || sel_data[HDR_READ_BIT]) begin
                        state_nxt = ADDR;
                    end else begin
                        byte_last = 1'b1;
                        state_nxt = ARB;
                    end
                end
            end
            ADDR: begin
                if (accept) state_nxt = LENA;
            end
            LENA: begin
                if (accept) state_nxt = LENB;
            end
            LENB: begin
                if (accept) begin
                    if (is_write) begin
                        state_nxt = PAYLOAD;
                    end else begin
                        byte_last = 1'b1;
                        state_nxt = ARB;
                    end
                end
            end
            PAYLOAD: begin
                if (accept && (pay_cnt == 17'd1)) begin
                    byte_last = 1'b1;
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ARB;
        else          state <= state_nxt;
    end

    // Grant lock, round-robin pointer, header/length capture and frame counting
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_index <= '0;
            rr_ptr      <= '0;
            frame_count <= '0;
            is_write    <= 1'b0;
            len_lsb     <= '0;
            pay_cnt     <= '0;
        end else begin
            if ((state == ARB) && rr_valid) grant_index <= rr_grant;
            if (accept && (state == HDR))   is_write <= sel_data[HDR_WRITE_BIT];
            if (accept && (state == LENA))  len_lsb <= sel_data[7:0];
            if (accept && (state == LENB) && is_write) begin
                pay_cnt <= ({sel_data[7:0], len_lsb} == 16'h0000) ? 17'h10000
                                                                  : {1'b0, sel_data[7:0], len_lsb};
            end
            if (accept && (state == PAYLOAD)) pay_cnt <= pay_cnt - 17'd1;
            if (byte_last) begin
                rr_ptr      <= (grant_index == 3'(NUM_PORTS-1)) ? 3'd0 : grant_index + 3'd1;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Single output register; contents held while the engine stalls
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tid    <= ID_DEST_WIDTH'(ID_BASE);
            m_axis_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tid    <= ID_DEST_WIDTH'(ID_BASE) + ID_DEST_WIDTH'(grant_index);
            m_axis_tlast  <= byte_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rfg_axis_frame_arbiter.sv
// Bench for rfg_axis_frame_arbiter: per-port frame queues feed the sources,
// and a frame-level reference model predicts the output byte stream.
module tb_rfg_axis_frame_arbiter;

    localparam int NP  = 4;
    localparam int IDB = 16;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [NP*8-1:0] s_axis_tdata;
    logic [NP-1:0]   s_axis_tvalid;
    logic [NP-1:0]   s_axis_tready;
    logic [7:0]      m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [7:0]      m_axis_tid;
    logic            m_axis_tlast;
    logic [2:0]      grant_index;
    logic            busy;
    logic [15:0]     frame_count;

    rfg_axis_frame_arbiter #(
        .NUM_PORTS     (NP),
        .DATA_WIDTH    (8),
        .ID_DEST_WIDTH (8),
        .ID_BASE       (IDB)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tlast  (m_axis_tlast),
        .grant_index   (grant_index),
        .busy          (busy),
        .frame_count   (frame_count)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Source queues ({is_header, byte}) and reference-model queues
    logic [8:0] src_q   [NP][$];
    logic [7:0] exp_q   [NP][$];
    int         exp_len [NP][$];
    logic [7:0] fb [$];

    logic [NP-1:0] fire = '0;
    int gap_pct  = 0;
    int rdy_mode = 0;

    // Frame length from the header and length bytes
    function automatic int frame_len(input logic [7:0] h, input logic [7:0] l0, input logic [7:0] l1);
        int n;
        n = int'({l1, l0});
        if (h[0]) return 4 + ((n == 0) ? 65536 : n);
        if (h[1]) return 4;
        return 1;
    endfunction

    task automatic start_frame(input logic [7:0] h, input logic [7:0] a,
                               input logic [7:0] l0, input logic [7:0] l1, input int nb);
        fb.delete();
        fb.push_back(h);
        if (nb > 1) begin
            fb.push_back(a);
            fb.push_back(l0);
            fb.push_back(l1);
        end
    endtask

    task automatic push_frame(input int p);
        int len;
        len = frame_len(fb[0], (fb.size() > 2) ? fb[2] : 8'h00, (fb.size() > 3) ? fb[3] : 8'h00);
        foreach (fb[i]) begin
            src_q[p].push_back({(i == 0), fb[i]});
            exp_q[p].push_back(fb[i]);
        end
        exp_len[p].push_back(len);
    endtask

    task automatic gen_write(input int p, input int n, input logic [7:0] h);
        start_frame(h, 8'($urandom), 8'(n), 8'(n >> 8), 4);
        for (int k = 0; k < ((n == 0) ? 65536 : n); k++) fb.push_back(8'($urandom));
        push_frame(p);
    endtask

    task automatic gen_random(input int p);
        int         r;
        logic [7:0] h;
        r = $urandom_range(3);
        h = 8'($urandom);
        if (r == 0) begin
            h[1:0] = 2'b00;
            start_frame(h, 8'h00, 8'h00, 8'h00, 1);
            push_frame(p);
        end else if (r == 1) begin
            h[1:0] = 2'b10;
            start_frame(h, 8'($urandom), 8'($urandom), 8'($urandom), 4);
            push_frame(p);
        end else begin
            h[0] = 1'b1;
            gen_write(p, $urandom_range(1, 6), h);
        end
    endtask

    // Source and sink drivers, updated just after each rising edge
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (fire[i] && (src_q[i].size() > 0)) void'(src_q[i].pop_front());
                if (src_q[i].size() == 0) begin
                    s_axis_tvalid[i] = 1'b0;
                end else if (s_axis_tvalid[i] && !fire[i]) begin
                    s_axis_tvalid[i] = 1'b1;
                end else if (src_q[i][0][8] || ($urandom_range(99) >= gap_pct)) begin
                    s_axis_tvalid[i]       = 1'b1;
                    s_axis_tdata[i*8 +: 8] = src_q[i][0][7:0];
                end else begin
                    s_axis_tvalid[i] = 1'b0;
                end
            end
            if (rdy_mode == 0)      m_axis_tready = 1'b1;
            else if (rdy_mode == 1) m_axis_tready = ~m_axis_tready;
            else                    m_axis_tready = 1'($urandom_range(1));
        end
    end

    // Reference model state
    int  cyc = 0;
    int  cur_port = -1;
    int  cur_rem = 0;
    int  rr_model = 0;
    int  model_frames = 0;
    int  out_cnt = 0;
    int  last_fire_cyc = 0;
    bit  have_prev = 0;
    bit  timing_chk = 0;
    bit  prev_stall = 0;
    logic [7:0] pd, pid;
    logic       pl;

    task automatic take_byte();
        int p;
        if (cur_port < 0) begin
            p = -1;
            for (int k = 0; k < NP; k++) begin
                if ((p < 0) && (exp_len[(rr_model + k) % NP].size() > 0)) p = (rr_model + k) % NP;
            end
            if (p < 0) begin
                check("unexpected_byte", {24'h0, m_axis_tdata}, 32'hFFFF_FFFF);
                return;
            end
            if (timing_chk && have_prev) check("bubble", cyc - last_fire_cyc, 2);
            cur_port = p;
            cur_rem  = exp_len[p].pop_front();
        end else if (timing_chk) begin
            check("throughput", cyc - last_fire_cyc, 1);
        end
        check("tid", m_axis_tid, IDB + cur_port);
        check("tdata", m_axis_tdata, exp_q[cur_port].pop_front());
        check("tlast", m_axis_tlast, (cur_rem == 1));
        cur_rem--;
        last_fire_cyc = cyc;
        out_cnt++;
        if (cur_rem == 0) begin
            rr_model = (cur_port + 1) % NP;
            cur_port = -1;
            model_frames++;
            have_prev = 1;
        end
    endtask

    // Output monitor, sampled on the falling edge
    initial begin
        forever begin
            @(negedge aclk);
            cyc++;
            fire = s_axis_tvalid & s_axis_tready;
            if (aresetn === 1'b1) begin
                check("tready_onehot", ($countones(s_axis_tready) <= 1), 1);
                if (prev_stall) begin
                    check("hold_valid", m_axis_tvalid, 1);
                    check("hold_data", m_axis_tdata, pd);
                    check("hold_tid", m_axis_tid, pid);
                    check("hold_tlast", m_axis_tlast, pl);
                end
                if (m_axis_tvalid && !m_axis_tready) check("tready_full", s_axis_tready, 0);
                if (m_axis_tvalid && m_axis_tready) take_byte();
                prev_stall = m_axis_tvalid && !m_axis_tready;
                pd  = m_axis_tdata;
                pid = m_axis_tid;
                pl  = m_axis_tlast;
            end else begin
                prev_stall = 0;
            end
        end
    end

    function automatic bit all_empty();
        bit e;
        e = (cur_port < 0);
        for (int i = 0; i < NP; i++) begin
            if ((src_q[i].size() != 0) || (exp_len[i].size() != 0)) e = 0;
        end
        return e;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((n < budget) && !all_empty()) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "_done"}, (n < budget), 1);
        repeat (3) @(negedge aclk);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_count"}, frame_count, 16'(model_frames));
    endtask

    task automatic new_scenario(input int gap, input int rdy, input bit tchk);
        gap_pct    = gap;
        rdy_mode   = rdy;
        timing_chk = tchk;
        have_prev  = 0;
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        int base;
        int n;
        aresetn       = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_mvalid", m_axis_tvalid, 0);
        check("rst_tready", s_axis_tready, 0);
        check("rst_grant", grant_index, 0);
        check("rst_count", frame_count, 0);
        check("rst_busy", busy, 0);
        check("rst_tid", m_axis_tid, IDB);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        @(posedge aclk); #2;
        aresetn = 1'b1;

        // Single write from port 0
        new_scenario(0, 0, 1);
        start_frame(8'h01, 8'h10, 8'h03, 8'h00, 4);
        fb.push_back(8'hAA); fb.push_back(8'hBB); fb.push_back(8'hCC);
        push_frame(0);
        wait_done("single_write", 200);
        check("single_write_frames", frame_count, 1);

        // Read followed by write on port 2, one-cycle bubble between them
        new_scenario(0, 0, 1);
        start_frame(8'h02, 8'h20, 8'h04, 8'h00, 4);
        push_frame(2);
        start_frame(8'h01, 8'h21, 8'h01, 8'h00, 4);
        fb.push_back(8'h55);
        push_frame(2);
        wait_done("read_write", 200);

        // Contention between ports 0, 1 and 3
        new_scenario(0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            gen_write(0, 1, 8'h01);
            gen_write(1, 1, 8'h01);
            gen_write(3, 1, 8'h01);
        end
        wait_done("contention", 400);

        // Alternating backpressure
        new_scenario(0, 1, 0);
        gen_write(1, 6, 8'h05);
        start_frame(8'h02, 8'h33, 8'h09, 8'h00, 4);
        push_frame(2);
        wait_done("backpressure", 400);

        // Edge frames: bare header and header with both read and write set
        new_scenario(0, 0, 1);
        start_frame(8'h00, 8'h00, 8'h00, 8'h00, 1);
        push_frame(1);
        start_frame(8'h03, 8'h40, 8'h02, 8'h00, 4);
        fb.push_back(8'h11); fb.push_back(8'h22);
        push_frame(1);
        start_frame(8'hF0, 8'h00, 8'h00, 8'h00, 1);
        push_frame(3);
        wait_done("edge", 200);

        // Randomised traffic with source gaps and random sink readiness
        new_scenario(30, 2, 0);
        for (int k = 0; k < 40; k++) gen_random($urandom_range(NP - 1));
        wait_done("random", 8000);

        // Write with length 0 carries 65536 payload bytes
        new_scenario(0, 0, 1);
        gen_write(2, 0, 8'h01);
        wait_done("len0", 66000);

        // Reset in the middle of a payload
        new_scenario(0, 0, 0);
        base = out_cnt;
        start_frame(8'h01, 8'h30, 8'h05, 8'h00, 4);
        for (int k = 0; k < 5; k++) fb.push_back(8'(8'hA0 + k));
        push_frame(1);
        n = 0;
        while ((n < 200) && (out_cnt - base < 6)) begin
            @(negedge aclk);
            n++;
        end
        check("midframe_reached", (n < 200), 1);
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        check("midrst_mvalid", m_axis_tvalid, 0);
        check("midrst_tready", s_axis_tready, 0);
        check("midrst_count", frame_count, 0);
        check("midrst_busy", busy, 0);
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            exp_len[i].delete();
        end
        s_axis_tvalid = '0;
        cur_port      = -1;
        rr_model      = 0;
        model_frames  = 0;
        have_prev     = 0;
        @(posedge aclk); #2;
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        gen_write(3, 2, 8'h01);
        gen_write(1, 1, 8'h01);
        gen_write(0, 3, 8'h01);
        wait_done("after_reset", 400);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rfg_axis_frame_arbiter.md
Name: rfg_axis_frame_arbiter

Overview:
- Shares the single register-protocol engine slave port between NUM_PORTS AXI-Stream I/O interfaces (UART, SPI, USB/FTDI bridges).
- Parses the register-protocol framing on the fly and switches grant only on frame boundaries, so a frame from one interface is never interleaved with another.
- Stamps each forwarded byte with the source port ID; the protocol engine copies it to its readback tdest, so answers route back to the requesting interface.

Parameters:
- NUM_PORTS, 4, number of slave input interfaces (2..8)
- DATA_WIDTH, 8, byte width; only 8 is supported
- ID_DEST_WIDTH, 8, width of m_axis_tid
- ID_BASE, 0, tid emitted for port 0; port i emits ID_BASE+i

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port i at bits [i*8+:8]
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tready  out  NUM_PORTS  per-port ready
- m_axis_tdata  out  DATA_WIDTH  byte to protocol engine
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  protocol engine ready
- m_axis_tid  out  ID_DEST_WIDTH  ID_BASE+grant index
- m_axis_tlast  out  1  last byte of a frame
- grant_index  out  3  currently/last granted port
- busy  out  1  a frame is in progress (state != ARB)
- frame_count  out  16  frames forwarded; wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync release): state=ARB, m_axis_tvalid=0, tlast=0, tdata=0, tid=ID_BASE, s_axis_tready=0, grant_index=0, rr_ptr=0, frame_count=0, payload counter=0. Reset mid-frame discards the partial frame; no byte is emitted after reset.
- Frame format: header (b0 write, b1 read, b2 addr incr, b3 rsvd, b7:4 vchannel), address, length LSB, length MSB, then payload only if write=1.
- Write wins when both b0 and b1 are set.
- Write payload count = length, where length 0 means 65536 (17-bit counter).
- A header with b0=b1=0 is a one-byte frame.
- A read frame ends after length MSB.
- Output stage is one register; a byte is accepted from the granted port when s_tvalid[g] && (!m_tvalid || m_tready). Only s_axis_tready[g] may be high; all others are 0. Latency is 1 cycle from acceptance to m_tvalid. Full throughput is 1 byte/cycle.
- m_tdata, m_tid and m_tlast are held stable while m_tvalid && !m_tready.
- State machine ARB -> HDR -> ADDR -> LENA -> LENB -> PAYLOAD -> ARB:
  - ARB: if any s_tvalid, grant the first requester at or after rr_ptr (circular scan); set grant_index, go to HDR. No byte is accepted in ARB, so there is a 1-cycle arbitration bubble per frame.
  - HDR: on accept, latch write/read bits. If neither bit is set: tlast=1, go to ARB. Otherwise go to ADDR.
  - ADDR and LENA: advance on accept. LENA latches the length LSB.
  - LENB: on accept, form the length. If write: load count (0 becomes 65536), go to PAYLOAD. Otherwise (read): tlast=1, go to ARB.
  - PAYLOAD: decrement on each accept; the byte with count==1 gets tlast=1, then go to ARB.
- On every transition to ARB: rr_ptr = grant+1 (mod NUM_PORTS) and frame_count increments.
- The grant is held through source tvalid gaps of any length. There is no timeout; an interface stalled mid-frame blocks others by design.
- A requester that raises tvalid while another is locked is served at the next ARB in round-robin order. A sole requester is re-granted itself after one bubble cycle.

Decomposition:
- Package rfg_protocol_pkg holds:
  - header_t struct (vchannel, rsvd, address_increment, read, write)
  - arb state enum
  - constants HDR_WRITE_BIT=0, HDR_READ_BIT=1, RFG_FRAME_HEADER_BYTES=4
- Shared with the protocol engine and readback routing.
- One sub-module: rfg_rr_grant, a combinational round-robin priority picker (req vector, rr_ptr -> grant index, grant_valid). Everything else lives in the top.

Test Plan:
- Single write: port 0 sends 01 10 03 00 AA BB CC, tready=1 -> 7 bytes out in order, tid=0, tlast only on CC, frame_count=1, busy low after.
- Single read: port 2 sends 02 20 04 00, then 01 21 01 00 55 -> first frame ends with tlast on byte 00 (4th) and tid=2; second frame forwarded after a 1-cycle bubble.
- Contention: ports 0, 1 and 3 all valid with 5-byte writes -> order 0,1,3,0…; no interleaving inside frames; s_axis_tready one-hot.
- Backpressure: m_axis_tready toggles 1010… during a frame -> no loss or duplication; data/tid/tlast held stable while stalled; s_axis_tready[g]=0 while the output register is full and unread.
- Edge frames: header 0x00 from port 1 -> single byte with tlast=1. Write with length 0x0000 -> 65536 payload bytes then tlast. Header 0x03 -> treated as write.
- Reset mid-payload (aresetn low for 1 cycle after 2 of 5 payload bytes) -> m_tvalid=0 and all tready=0 immediately; after release, ARB grants port 0 first; frame_count=0.
